// File: rtl/ipc_mailbox_ram.sv
// ============================================================================
// ipc_mailbox_ram : dual-port IPC buffer (console port A / MCU port B) with
//                   NUM_CH doorbell channels per direction.  Rev 1.0
// ============================================================================
`default_nettype none

module ipc_mailbox_ram #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 512,
  parameter  int NUM_CH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A (console bus)
  input  logic              i_sel_a,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [WIDTH-1:0]  i_wdata_a,
  output logic [WIDTH-1:0]  o_rdata_a,
  input  logic [NUM_CH-1:0] i_ring_a,
  input  logic [NUM_CH-1:0] i_ack_a,
  input  logic [NUM_CH-1:0] i_mask_a,
  output logic [NUM_CH-1:0] o_pending_a,
  output logic [NUM_CH-1:0] o_overrun_a,
  output logic              o_irq_a,
  // port B (MCU / SPI)
  input  logic              i_sel_b,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [WIDTH-1:0]  i_wdata_b,
  output logic [WIDTH-1:0]  o_rdata_b,
  input  logic [NUM_CH-1:0] i_ring_b,
  input  logic [NUM_CH-1:0] i_ack_b,
  input  logic [NUM_CH-1:0] i_mask_b,
  output logic [NUM_CH-1:0] o_pending_b,
  output logic [NUM_CH-1:0] o_overrun_b,
  output logic              o_irq_b
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rdata_a, r_rdata_b;
  logic [NUM_CH-1:0] r_pend_a, r_pend_b, r_ovr_a, r_ovr_b;
  logic              r_irq_a, r_irq_b;

  logic w_in_a, w_in_b, w_wr_a, w_wr_b, w_rd_a, w_rd_b, w_collide;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign w_in_a    = (32'(i_addr_a) < 32'(DEPTH));
  assign w_in_b    = (32'(i_addr_b) < 32'(DEPTH));
  assign w_wr_a    = i_sel_a & i_we_a & w_in_a;
  assign w_wr_b    = i_sel_b & i_we_b & w_in_b;
  assign w_rd_a    = i_sel_a & ~i_we_a;
  assign w_rd_b    = i_sel_b & ~i_we_b;
  assign w_collide = w_wr_a & w_wr_b & (i_addr_a == i_addr_b);

  // Port A owns a same-address double write; B's write is dropped.
  always_ff @(posedge clk) begin
    if (w_wr_b && !w_collide) r_mem[i_addr_b] <= i_wdata_b;
    if (w_wr_a)               r_mem[i_addr_a] <= i_wdata_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (w_rd_a) r_rdata_a <= w_in_a ? r_mem[i_addr_a] : '0;
      if (w_rd_b) r_rdata_b <= w_in_b ? r_mem[i_addr_b] : '0;
    end
  end

  // A ring coinciding with an ack wins; overrun only counts un-acked repeats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_a <= '0;
      r_pend_b <= '0;
      r_ovr_a  <= '0;
      r_ovr_b  <= '0;
      r_irq_a  <= 1'b0;
      r_irq_b  <= 1'b0;
    end else begin
      r_pend_b <= i_ring_a | (r_pend_b & ~i_ack_b);
      r_ovr_b  <= (r_ovr_b & ~i_ack_b) | (i_ring_a & r_pend_b & ~i_ack_b);
      r_pend_a <= i_ring_b | (r_pend_a & ~i_ack_a);
      r_ovr_a  <= (r_ovr_a & ~i_ack_a) | (i_ring_b & r_pend_a & ~i_ack_a);
      r_irq_a  <= |(r_pend_a & i_mask_a);
      r_irq_b  <= |(r_pend_b & i_mask_b);
    end
  end

  assign o_rdata_a   = r_rdata_a;
  assign o_rdata_b   = r_rdata_b;
  assign o_pending_a = r_pend_a;
  assign o_pending_b = r_pend_b;
  assign o_overrun_a = r_ovr_a;
  assign o_overrun_b = r_ovr_b;
  assign o_irq_a     = r_irq_a;
  assign o_irq_b     = r_irq_b;

endmodule

`default_nettype wire
